// File: rtl/ps2_key_tracker_pkg.sv
// Shared PS/2 scan-code constants, parser state encoding and event payload.
package ps2_key_tracker_pkg;

    localparam logic [7:0]  PS2_BREAK = 8'hF0;
    localparam logic [7:0]  PS2_EXT   = 8'hE0;
    localparam int unsigned GAP_W     = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } ps2_state_e;

    // Decoded key event as presented on the evt_* outputs.
    typedef struct packed {
        logic       brk;
        logic       rpt;
        logic       ext;
        logic [7:0] code;
    } key_evt_t;

    // Keyboard status/ack bytes that carry no key information.
    function automatic logic is_dropped(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_fifo_pop.sv
// Pop handshake towards the ps2_keyboard FIFO.
//  clock, reset       : system clock, synchronous active-high reset
//  kbd_data/kbd_ready : FIFO head byte and non-empty flag
//  nextdata_n         : registered active-low pop strobe, one cycle per accepted byte
//  pop_vld_c/pop_byte_c : combinational accept qualifier and the byte taken at this edge
module ps2_fifo_pop
    import ps2_key_tracker_pkg::*;
#(
    parameter int unsigned POP_GAP = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    output logic       nextdata_n,
    output logic       pop_vld_c,
    output logic [7:0] pop_byte_c
);

    logic [GAP_W-1:0] gap_q;

    // kbd_ready is only trusted once the FIFO pointer has settled after the last pop.
    assign pop_vld_c  = kbd_ready && nextdata_n && (gap_q == '0);
    assign pop_byte_c = kbd_data;

    // Strobe low for exactly one cycle, then hold off for POP_GAP cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            nextdata_n <= 1'b1;
            gap_q      <= '0;
        end else if (pop_vld_c) begin
            nextdata_n <= 1'b0;
        end else if (!nextdata_n) begin
            nextdata_n <= 1'b1;
            gap_q      <= GAP_W'(POP_GAP);
        end else if (gap_q != '0) begin
            gap_q      <= gap_q - GAP_W'(1);
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Parses scan-code bytes popped from ps2_keyboard into make/break/repeat events
// and tracks the currently held key.
//  clock, reset            : system clock, synchronous active-high reset
//  kbd_data/ready/overflow : FIFO interface from ps2_keyboard
//  nextdata_n              : active-low pop strobe
//  key_code/key_ext/key_held : last made key and whether it is still down
//  press_count             : new presses (typematic repeats excluded), wrapping
//  evt_*                   : one-cycle event pulse with its qualifiers
//  ovf_sticky              : latched FIFO overflow
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int unsigned POP_GAP = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_held,
    output logic [CNT_W-1:0] press_count,
    output logic             evt_valid,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             ovf_sticky
);

    logic       pop_vld_c;
    logic [7:0] pop_byte_c;

    ps2_state_e state_q, state_d;
    key_evt_t   evt_q;
    logic       fire_c, brk_c, ext_c, match_c;

    ps2_fifo_pop #(.POP_GAP(POP_GAP)) u_pop (
        .clock      (clock),
        .reset      (reset),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .nextdata_n (nextdata_n),
        .pop_vld_c  (pop_vld_c),
        .pop_byte_c (pop_byte_c)
    );

    // Parser state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Prefix parsing; a stray prefix inside a break sequence aborts it silently.
    always_comb begin
        state_d = state_q;
        fire_c  = 1'b0;
        brk_c   = 1'b0;
        ext_c   = 1'b0;
        if (pop_vld_c) begin
            case (state_q)
                S_IDLE: begin
                    if (pop_byte_c == PS2_BREAK)    state_d = S_BRK;
                    else if (pop_byte_c == PS2_EXT) state_d = S_EXT;
                    else if (!is_dropped(pop_byte_c)) fire_c = 1'b1;
                end
                S_EXT: begin
                    if (pop_byte_c == PS2_BREAK)    state_d = S_EXT_BRK;
                    else if (pop_byte_c != PS2_EXT) begin
                        state_d = S_IDLE;
                        fire_c  = 1'b1;
                        ext_c   = 1'b1;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (pop_byte_c != PS2_BREAK && pop_byte_c != PS2_EXT) begin
                        fire_c = 1'b1;
                        brk_c  = 1'b1;
                        ext_c  = (state_q == S_EXT_BRK);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign match_c = key_held && (key_ext == ext_c) && (key_code == pop_byte_c);

    // Event pulse, held-key tracking and overflow latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            evt_valid   <= 1'b0;
            evt_q       <= '0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_held    <= 1'b0;
            press_count <= '0;
            ovf_sticky  <= 1'b0;
        end else begin
            ovf_sticky <= ovf_sticky | kbd_overflow;
            evt_valid  <= fire_c;
            evt_q.brk  <= fire_c && brk_c;
            evt_q.rpt  <= fire_c && !brk_c && match_c;
            if (fire_c) begin
                evt_q.code <= pop_byte_c;
                evt_q.ext  <= ext_c;
            end
            if (fire_c && !brk_c && !match_c) begin
                key_code    <= pop_byte_c;
                key_ext     <= ext_c;
                key_held    <= 1'b1;
                press_count <= press_count + CNT_W'(1);
            end
            if (fire_c && brk_c && match_c) key_held <= 1'b0;
        end
    end

    assign evt_break  = evt_q.brk;
    assign evt_repeat = evt_q.rpt;
    assign evt_code   = evt_q.code;
    assign evt_ext    = evt_q.ext;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomized and directed check of ps2_key_tracker against a byte-level reference model.
module tb_ps2_key_tracker;

    localparam int unsigned POP_GAP = 2;
    localparam int unsigned CNT_W   = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       kbd_data = 8'h00;
    logic             kbd_ready = 1'b0;
    logic             kbd_overflow = 1'b0;
    logic             nextdata_n;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_held;
    logic [CNT_W-1:0] press_count;
    logic             evt_valid, evt_break, evt_repeat, evt_ext;
    logic [7:0]       evt_code;
    logic             ovf_sticky;

    ps2_key_tracker #(.POP_GAP(POP_GAP), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow), .nextdata_n(nextdata_n), .key_code(key_code),
        .key_ext(key_ext), .key_held(key_held), .press_count(press_count),
        .evt_valid(evt_valid), .evt_break(evt_break), .evt_repeat(evt_repeat),
        .evt_code(evt_code), .evt_ext(evt_ext), .ovf_sticky(ovf_sticky)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // FIFO contents seen by the DUT
    logic [7:0] q[$];

    // reference model state
    int   last_pulse = -100;
    bit   m_ext_pend, m_brk_pend;
    bit   m_held, m_kext, m_ovf;
    int   m_code, m_count;
    bit   x_valid, x_brk, x_rpt, x_ext;
    int   x_code;

    // observations of the DUT for directed literal checks
    int   obs_pulses, obs_events, obs_repeats, obs_breaks;
    int   obs_last_ext, obs_last_code;
    int   pulse_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit dropped(input int b);
        return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
    endfunction

    task automatic model_reset();
        m_ext_pend = 0; m_brk_pend = 0; m_held = 0; m_kext = 0; m_ovf = 0;
        m_code = 0; m_count = 0; last_pulse = -100;
        x_valid = 0; x_brk = 0; x_rpt = 0; x_ext = 0; x_code = 0;
    endtask

    // Apply one popped byte to the model; sets x_* when an event results.
    task automatic consume(input int b);
        bit e;
        if (m_brk_pend) begin
            e = m_ext_pend;
            m_brk_pend = 0; m_ext_pend = 0;
            if (b != 8'hF0 && b != 8'hE0) begin
                x_valid = 1; x_brk = 1; x_rpt = 0; x_ext = e; x_code = b;
                if (m_held && m_code == b && m_kext == e) m_held = 0;
            end
        end else if (b == 8'hF0) begin
            m_brk_pend = 1;
        end else if (b == 8'hE0) begin
            m_ext_pend = 1;
        end else if (!m_ext_pend && dropped(b)) begin
            // status byte, ignored
        end else begin
            e = m_ext_pend;
            m_ext_pend = 0;
            x_valid = 1; x_brk = 0; x_ext = e; x_code = b;
            x_rpt = m_held && m_code == b && m_kext == e;
            if (!x_rpt) begin
                m_code = b; m_kext = e; m_held = 1;
                m_count = (m_count + 1) % (1 << CNT_W);
            end
        end
    endtask

    // One clock: advance FIFO + model, then compare every output.
    task automatic tick();
        bit rst_e, rdy_e, ovf_e, exp_pulse;
        rst_e = reset; rdy_e = kbd_ready; ovf_e = kbd_overflow;
        @(posedge clock);
        #1;
        cyc++;
        x_valid = 0;
        exp_pulse = 0;
        if (rst_e) begin
            model_reset();
        end else begin
            m_ovf = m_ovf | ovf_e;
            exp_pulse = rdy_e && (cyc - last_pulse >= int'(POP_GAP) + 2);
            if (exp_pulse) begin
                last_pulse = cyc;
                consume(int'(q.pop_front()));
            end
        end
        check("nextdata_n", 32'(nextdata_n), 32'(!exp_pulse));
        check("evt_valid", 32'(evt_valid), 32'(x_valid));
        if (x_valid) begin
            check("evt_break", 32'(evt_break), 32'(x_brk));
            check("evt_repeat", 32'(evt_repeat), 32'(x_rpt));
            check("evt_code", 32'(evt_code), 32'(x_code));
            check("evt_ext", 32'(evt_ext), 32'(x_ext));
        end
        check("key_held", 32'(key_held), 32'(m_held));
        check("key_code", 32'(key_code), 32'(m_code));
        check("key_ext", 32'(key_ext), 32'(m_kext));
        check("press_count", 32'(press_count), 32'(m_count));
        check("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
        if (!nextdata_n) begin obs_pulses++; pulse_cyc.push_back(cyc); end
        if (evt_valid) begin
            obs_events++;
            if (evt_repeat) obs_repeats++;
            if (evt_break) obs_breaks++;
            obs_last_ext = int'(evt_ext);
            obs_last_code = int'(evt_code);
        end
        kbd_ready = (q.size() != 0);
        kbd_data  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        kbd_ready = 1'b1;
        kbd_data  = q[0];
    endtask

    task automatic clear_obs();
        obs_pulses = 0; obs_events = 0; obs_repeats = 0; obs_breaks = 0;
        obs_last_ext = -1; obs_last_code = -1;
        pulse_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_obs();
    endtask

    // Run until the FIFO is empty and the last pop has completed, bounded.
    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || n < 6) && n < 400) begin
            tick();
            if (q.size() != 0) n = 0; else n++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        model_reset();
        clear_obs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        // reset values
        check("rst_nextdata_n", 32'(nextdata_n), 32'd1);
        check("rst_press_count", 32'(press_count), 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        clear_obs();

        // 1) make then break of 1C
        push(8'h1C); push(8'hF0); push(8'h1C);
        drain();
        check("t1_pulses", 32'(obs_pulses), 32'd3);
        check("t1_events", 32'(obs_events), 32'd2);
        check("t1_breaks", 32'(obs_breaks), 32'd1);
        check("t1_count", 32'(press_count), 32'd1);
        check("t1_held", 32'(key_held), 32'd0);
        check("t1_code", 32'(key_code), 32'h1C);

        // 2) typematic repeats
        do_reset();
        push(8'h1B); push(8'h1B); push(8'h1B); push(8'hF0); push(8'h1B);
        drain();
        check("t2_repeats", 32'(obs_repeats), 32'd2);
        check("t2_count", 32'(press_count), 32'd1);
        check("t2_held", 32'(key_held), 32'd0);

        // 3) extended make/break
        do_reset();
        push(8'hE0); push(8'h75);
        drain();
        check("t3_held", 32'(key_held), 32'd1);
        check("t3_key_ext", 32'(key_ext), 32'd1);
        check("t3_evt_ext", 32'(obs_last_ext), 32'd1);
        push(8'hE0); push(8'hF0); push(8'h75);
        drain();
        check("t3_rel_held", 32'(key_held), 32'd0);
        check("t3_rel_code", 32'(obs_last_code), 32'h75);
        check("t3_rel_ext", 32'(key_ext), 32'd1);

        // 4) back-to-back throughput with 5 bytes queued
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h21 + i));
        drain();
        check("t4_pulses", 32'(obs_pulses), 32'd5);
        for (int i = 1; i < pulse_cyc.size(); i++)
            check("t4_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'(POP_GAP + 2));
        check("t4_count", 32'(press_count), 32'd5);

        // 5) counter wrap and overflow latch
        do_reset();
        for (int i = 0; i < 256; i++) begin
            push((i % 2 == 0) ? 8'h1C : 8'h1B);
            drain();
        end
        check("t5_wrap", 32'(press_count), 32'd0);
        kbd_overflow = 1'b1;
        tick();
        kbd_overflow = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t5_ovf", 32'(ovf_sticky), 32'd1);
        do_reset();
        check("t5_ovf_clr", 32'(ovf_sticky), 32'd0);

        // 6) reset discards a pending E0 prefix; status bytes are dropped
        push(8'hE0);
        drain();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_obs();
        push(8'h1C);
        drain();
        check("t6_events", 32'(obs_events), 32'd1);
        check("t6_ext", 32'(obs_last_ext), 32'd0);
        push(8'hAA);
        drain();
        check("t6_drop", 32'(obs_events), 32'd1);

        // random traffic with occasional overflow and reset
        do_reset();
        for (int i = 0; i < 700; i++) begin
            int sel;
            logic [7:0] b;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: b = 8'h1C;
                1: b = 8'h1B;
                2: b = 8'h75;
                3, 4: b = 8'hF0;
                5: b = 8'hE0;
                6: b = ($urandom_range(0, 1) != 0) ? 8'hAA : 8'hFA;
                default: b = 8'($urandom_range(0, 255));
            endcase
            if (q.size() < 8) push(b);
            kbd_overflow = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            repeat (int'($urandom_range(1, 4))) begin
                tick();
                kbd_overflow = 1'b0;
                reset = 1'b0;
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
